// File: rtl/debug_uart_cmd_rx_if.sv
// Signal bundle between the debug UART command receiver and the SoC top level.
// The receiver uses the slave modport; the host/top side uses master.
interface debug_uart_cmd_rx_if;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_error;
   logic       step_pulse;
   logic       continuous_mode;
   logic       pc_inst_trigger;
   logic       reg_trigger;
   logic       alu_trigger;
   logic       cmd_error;
   logic [2:0] state_dbg;

   // Strobes are single-cycle and carry no back-pressure: rx_valid marks the one
   // cycle in which rx_data and the matching command strobe are valid together.
   modport slave (
      input  rx,
      output rx_data, rx_valid, frame_error, step_pulse, continuous_mode,
             pc_inst_trigger, reg_trigger, alu_trigger, cmd_error, state_dbg
   );

   modport master (
      output rx,
      input  rx_data, rx_valid, frame_error, step_pulse, continuous_mode,
             pc_inst_trigger, reg_trigger, alu_trigger, cmd_error, state_dbg
   );
endinterface

// File: rtl/debug_uart_cmd_rx.sv
// 8N1 UART receiver that decodes single-character debug commands into control strobes.
// Optional macro CMD_CASE_INSENSITIVE_EN makes uppercase command letters decode like lowercase.
module debug_uart_cmd_rx #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 115200
) (
   input  logic               clk,
   input  logic               reset,
   debug_uart_cmd_rx_if.slave bus
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_IDLE = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic             rx_meta_q, rx_s_q;
   logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_error_q, frame_error_d;
   logic             step_q, step_d;
   logic             cont_q, cont_d;
   logic             pc_q, pc_d;
   logic             reg_q, reg_d;
   logic             alu_q, alu_d;
   logic             cmd_err_q, cmd_err_d;

   logic dec_step, dec_pc, dec_reg, dec_alu, dec_toggle, dec_err;

   // Decode looks at the shift register directly so the strobe can be registered
   // alongside rx_valid in the stop-bit decision cycle.
   always_comb begin
      dec_step   = 1'b0;
      dec_pc     = 1'b0;
      dec_reg    = 1'b0;
      dec_alu    = 1'b0;
      dec_toggle = 1'b0;
      dec_err    = 1'b0;
      case (shift_q)
         8'h73: dec_step   = 1'b1;
         8'h70: dec_pc     = 1'b1;
         8'h72: dec_reg    = 1'b1;
         8'h61: dec_alu    = 1'b1;
         8'h63: dec_toggle = 1'b1;
`ifdef CMD_CASE_INSENSITIVE_EN
         8'h53: dec_step   = 1'b1;
         8'h50: dec_pc     = 1'b1;
         8'h52: dec_reg    = 1'b1;
         8'h41: dec_alu    = 1'b1;
         8'h43: dec_toggle = 1'b1;
`endif
         default: dec_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      clk_cnt_d     = clk_cnt_q;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      rx_data_d     = rx_data_q;
      cont_d        = cont_q;
      rx_valid_d    = 1'b0;
      frame_error_d = 1'b0;
      step_d        = 1'b0;
      pc_d          = 1'b0;
      reg_d         = 1'b0;
      alu_d         = 1'b0;
      cmd_err_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d   = S_START;
               clk_cnt_d = '0;
            end
         end
         S_START: begin
            if (clk_cnt_q == HALF_LAST) begin
               clk_cnt_d = '0;
               if (!rx_s_q) begin
                  state_d   = S_DATA;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               shift_d   = {rx_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = S_STOP;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               if (rx_s_q) begin
                  state_d    = S_IDLE;
                  rx_valid_d = 1'b1;
                  rx_data_d  = shift_q;
                  step_d     = dec_step;
                  pc_d       = dec_pc;
                  reg_d      = dec_reg;
                  alu_d      = dec_alu;
                  cmd_err_d  = dec_err;
                  cont_d     = cont_q ^ dec_toggle;
               end else begin
                  state_d       = S_WAIT_IDLE;
                  frame_error_d = 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         S_WAIT_IDLE: begin
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q     <= 1'b1;
         rx_s_q        <= 1'b1;
         state_q       <= S_IDLE;
         clk_cnt_q     <= '0;
         bit_idx_q     <= 3'd0;
         shift_q       <= 8'h00;
         rx_data_q     <= 8'h00;
         rx_valid_q    <= 1'b0;
         frame_error_q <= 1'b0;
         step_q        <= 1'b0;
         cont_q        <= 1'b0;
         pc_q          <= 1'b0;
         reg_q         <= 1'b0;
         alu_q         <= 1'b0;
         cmd_err_q     <= 1'b0;
      end else begin
         rx_meta_q     <= bus.rx;
         rx_s_q        <= rx_meta_q;
         state_q       <= state_d;
         clk_cnt_q     <= clk_cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         frame_error_q <= frame_error_d;
         step_q        <= step_d;
         cont_q        <= cont_d;
         pc_q          <= pc_d;
         reg_q         <= reg_d;
         alu_q         <= alu_d;
         cmd_err_q     <= cmd_err_d;
      end
   end

   assign bus.rx_data         = rx_data_q;
   assign bus.rx_valid        = rx_valid_q;
   assign bus.frame_error     = frame_error_q;
   assign bus.step_pulse      = step_q;
   assign bus.continuous_mode = cont_q;
   assign bus.pc_inst_trigger = pc_q;
   assign bus.reg_trigger     = reg_q;
   assign bus.alu_trigger     = alu_q;
   assign bus.cmd_error       = cmd_err_q;
   assign bus.state_dbg       = state_q;

endmodule

// File: tb/tb_debug_uart_cmd_rx.sv
// Directed plus randomized bench for debug_uart_cmd_rx at 10 clocks per bit,
// checked against a byte-level command model.
module tb_debug_uart_cmd_rx;
   localparam int CPB = 10;

   logic clk = 1'b0;
   logic reset = 1'b1;

   debug_uart_cmd_rx_if bus ();

   debug_uart_cmd_rx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Entries are {continuous_mode, step, pc, reg, alu, cmd_error, rx_data}.
   logic [13:0] exp_q[$];
   logic [13:0] obs_q[$];
   logic        model_cm = 1'b0;

   int     n_ferr = 0, n_any = 0;
   int     orphan_err = 0, multi_err = 0, width_err = 0;
   int     last_lat = 0;
   time    fall_t = 0;
   logic [6:0] prev_str = '0;

   // Monitor samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      logic [4:0] sv;
      logic [6:0] all_str;
      sv = {bus.step_pulse, bus.pc_inst_trigger, bus.reg_trigger, bus.alu_trigger, bus.cmd_error};
      all_str = {bus.rx_valid, bus.frame_error, sv};
      if (bus.rx_valid) begin
         obs_q.push_back({bus.continuous_mode, sv, bus.rx_data});
         last_lat = int'(($time - fall_t) / 10);
      end
      if (bus.frame_error) n_ferr++;
      if (all_str != 0) n_any++;
      if (!bus.rx_valid && sv != 0) orphan_err++;
      if ($countones(sv) > 1) multi_err++;
      if ((all_str & prev_str) != 0) width_err++;
      prev_str = all_str;
   end

   function automatic logic [4:0] model_vec(input logic [7:0] b);
      logic [7:0] k;
      k = b;
`ifdef CMD_CASE_INSENSITIVE_EN
      if (b >= "A" && b <= "Z") k = b + 8'd32;
`endif
      case (k)
         "s":     return 5'b10000;
         "p":     return 5'b01000;
         "r":     return 5'b00100;
         "a":     return 5'b00010;
         "c":     return 5'b00000;
         default: return 5'b00001;
      endcase
   endfunction

   function automatic logic model_toggles(input logic [7:0] b);
`ifdef CMD_CASE_INSENSITIVE_EN
      return (b == "c") || (b == "C");
`else
      return (b == "c");
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Caller is on a falling edge; the task returns on a falling edge.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
      bus.rx = 1'b0;
      fall_t = $time;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      bus.rx = stop_bit;
      if (stop_bit) begin
         if (model_toggles(b)) model_cm = ~model_cm;
         exp_q.push_back({model_cm, model_vec(b), b});
      end
      repeat (CPB) @(negedge clk);
      if (stop_bit) bus.rx = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic compare_events(input string tag);
      logic [13:0] o, e;
      repeat (10) @(negedge clk);
      check({tag, "_count"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         check({tag, "_event"}, o, e);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   function automatic logic [16:0] out_vec();
      return {bus.rx_data, bus.rx_valid, bus.frame_error, bus.step_pulse, bus.continuous_mode,
              bus.pc_inst_trigger, bus.reg_trigger, bus.alu_trigger, bus.cmd_error};
   endfunction

   initial begin
      int snap;
      logic [7:0] b;
      bus.rx = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_outputs", out_vec(), 17'd0);
      repeat (5) @(negedge clk);

      send_byte(8'h73, 1'b1, 5);
      check("latency_in_range", (last_lat >= 97 && last_lat <= 99), 1);
      compare_events("step");

      send_byte(8'h63, 1'b1, 0);
      send_byte(8'h63, 1'b1, 5);
      compare_events("cont_b2b");

      send_byte(8'h55, 1'b1, 5);
      compare_events("non_cmd");

      snap = n_ferr;
      send_byte(8'h70, 1'b0, 0);
      repeat (30) @(negedge clk);
      bus.rx = 1'b1;
      repeat (5) @(negedge clk);
      send_byte(8'h72, 1'b1, 5);
      check("frame_error_once", n_ferr - snap, 1);
      compare_events("after_break");

      snap = n_any;
      bus.rx = 1'b0;
      repeat (3) @(negedge clk);
      bus.rx = 1'b1;
      repeat (20) @(negedge clk);
      check("glitch_silent", n_any - snap, 0);
      send_byte(8'h61, 1'b1, 5);
      compare_events("after_glitch");

      send_byte(8'h63, 1'b1, 5);
      compare_events("cont_on");
      check("cont_set", bus.continuous_mode, 1);

      // Partial frame: start bit plus four data bits of 0x70, then reset.
      snap = n_any;
      bus.rx = 1'b0;
      repeat (CPB * 5) @(negedge clk);
      reset = 1'b1;
      bus.rx = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_mid_frame_outputs", out_vec(), 17'd0);
      reset = 1'b0;
      model_cm = 1'b0;
      repeat (120) @(negedge clk);
      check("reset_mid_frame_silent", n_any - snap, 0);
      check("reset_mid_frame_no_event", obs_q.size(), 0);
      send_byte(8'h61, 1'b1, 5);
      compare_events("after_reset");

      send_byte(8'h53, 1'b1, 5);
      compare_events("upper_s");

      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            case ($urandom_range(0, 9))
               0: b = "s"; 1: b = "p"; 2: b = "r"; 3: b = "a"; 4: b = "c";
               5: b = "S"; 6: b = "P"; 7: b = "R"; 8: b = "A"; default: b = "C";
            endcase
         end else begin
            b = 8'($urandom_range(0, 255));
         end
         send_byte(b, 1'b1, $urandom_range(0, 4));
      end
      compare_events("random");
      check("cont_final", bus.continuous_mode, model_cm);

      check("orphan_strobes", orphan_err, 0);
      check("multi_strobes", multi_err, 0);
      check("wide_strobes", width_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
